// File: rtl/aes_iter_core.sv
// aes_iter_core: round-iterative AES encryption core (AES-128/192/256).
// Key and plaintext arrive as a word-serial stream of IO_W bits, MSB first.
// The ciphertext leaves the same way. The key is expanded once into a
// 60-word round-key store, so later blocks can reuse it without reloading.
// One full AES round is computed per clock: 16 state S-boxes plus 4
// key-expansion S-boxes.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready/in_data  input beat handshake (key beats, then data beats)
//   in_new_key, key_len        request qualifiers, sampled on the first beat
//   out_valid/out_ready        output beat handshake
//   out_data/out_last/out_err  ciphertext beat, final-beat marker, no-key error
//   busy                       core is not idle
module aes_iter_core #(
    parameter int IO_W      = 8,
    parameter int KEY_W_MAX = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IO_W-1:0] in_data,
    input  logic            in_new_key,
    input  logic [1:0]      key_len,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IO_W-1:0] out_data,
    output logic            out_last,
    output logic            out_err,
    output logic            busy
);
    localparam int         DB      = 128 / IO_W;
    localparam logic [5:0] DB_LAST = 6'(DB - 1);
    localparam int         KWORDS  = KEY_W_MAX / 32;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_KEY, S_LOAD_DATA, S_KEYEXP, S_INIT, S_ROUND, S_OUTPUT
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte n of the 128-bit state sits at [127-8n -: 8]; state[row][col] = byte[row+4*col]
    function automatic logic [127:0] aes_round(input logic [127:0] st,
                                               input logic [127:0] rk,
                                               input logic         last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int n = 0; n < 16; n++) b[n] = sbox(st[127-8*n -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rw = 0; rw < 4; rw++)
                t[rw+4*c] = b[rw + 4*((c+rw)%4)];
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (last)
                r[127-32*c -: 32] = {a0, a1, a2, a3};
            else
                r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return r ^ rk;
    endfunction

    state_t               r_state, w_next;
    logic [KEY_W_MAX-1:0] r_key;
    logic [127:0]         r_data;
    logic [31:0]          r_w [60];
    logic [5:0]           r_cnt;
    logic [3:0]           r_nk, r_kmod, r_round;
    logic [7:0]           r_rcon;
    logic                 r_key_ok, r_new_key, r_err;

    logic         w_in_fire, w_out_fire;
    logic [3:0]   w_nk_req, w_nr;
    logic [5:0]   w_kb_last, w_exp_last, w_rk_base;
    logic [31:0]  w_prev, w_sub, w_temp, w_new_word;
    logic [127:0] w_rk;

    assign in_ready  = !rst && (r_state == S_IDLE || r_state == S_LOAD_KEY || r_state == S_LOAD_DATA);
    assign out_valid = !rst && (r_state == S_OUTPUT);
    assign out_data  = (out_valid && !r_err) ? r_data[127 -: IO_W] : '0;
    assign out_last  = out_valid && (r_cnt == DB_LAST);
    assign out_err   = out_valid && r_err;
    assign busy      = !rst && (r_state != S_IDLE);

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    // A 128-bit-only build ignores key_len entirely
    assign w_nk_req   = (KEY_W_MAX >= 256 && key_len == 2'b10) ? 4'd8 :
                        (KEY_W_MAX >= 192 && key_len == 2'b01) ? 4'd6 : 4'd4;
    assign w_nr       = r_nk + 4'd6;
    assign w_kb_last  = 6'((32 * int'(r_nk)) / IO_W - 1);
    assign w_exp_last = {w_nr, 2'b11};
    assign w_rk_base  = {r_round, 2'b00};
    assign w_rk       = {r_w[w_rk_base], r_w[w_rk_base + 6'd1],
                         r_w[w_rk_base + 6'd2], r_w[w_rk_base + 6'd3]};

    // Key expansion: w[i] = w[i-Nk] ^ f(w[i-1]); r_kmod tracks i mod Nk
    assign w_prev = r_w[r_cnt - 6'd1];
    assign w_sub  = sub_word((r_kmod == 4'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev);
    always_comb begin
        w_temp = w_prev;
        if (r_kmod == 4'd0)
            w_temp = w_sub ^ {r_rcon, 24'h000000};
        else if (r_nk == 4'd8 && r_kmod == 4'd4)
            w_temp = w_sub;
    end
    assign w_new_word = r_w[r_cnt - {2'b00, r_nk}] ^ w_temp;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_in_fire) w_next = in_new_key ? S_LOAD_KEY : S_LOAD_DATA;
            S_LOAD_KEY:  if (w_in_fire && r_cnt == w_kb_last) w_next = S_LOAD_DATA;
            S_LOAD_DATA: if (w_in_fire && r_cnt == DB_LAST) w_next = r_new_key ? S_KEYEXP : S_INIT;
            S_KEYEXP:    if (r_cnt == w_exp_last) w_next = S_INIT;
            // A block without a valid key skips the rounds and is returned flagged
            S_INIT:      w_next = r_err ? S_OUTPUT : S_ROUND;
            S_ROUND:     if (r_round == w_nr) w_next = S_OUTPUT;
            S_OUTPUT:    if (w_out_fire && r_cnt == DB_LAST) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_nk      <= '0;
            r_kmod    <= '0;
            r_round   <= '0;
            r_rcon    <= '0;
            r_key_ok  <= 1'b0;
            r_new_key <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_in_fire) begin
                    r_cnt     <= 6'd1;
                    r_new_key <= in_new_key;
                    r_err     <= 1'b0;
                    if (in_new_key) begin
                        r_nk     <= w_nk_req;
                        r_key_ok <= 1'b0;
                    end
                end
                S_LOAD_KEY: if (w_in_fire)
                    r_cnt <= (r_cnt == w_kb_last) ? 6'd0 : r_cnt + 6'd1;
                S_LOAD_DATA: if (w_in_fire) begin
                    if (r_cnt == DB_LAST) begin
                        r_cnt   <= r_new_key ? {2'b00, r_nk} : 6'd0;
                        r_round <= '0;
                        r_kmod  <= '0;
                        r_rcon  <= 8'h01;
                        r_err   <= !r_new_key && !r_key_ok;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_KEYEXP: begin
                    r_cnt  <= (r_cnt == w_exp_last) ? 6'd0 : r_cnt + 6'd1;
                    r_kmod <= (r_kmod == r_nk - 4'd1) ? 4'd0 : r_kmod + 4'd1;
                    if (r_kmod == 4'd0) r_rcon <= xtime(r_rcon);
                    if (r_cnt == w_exp_last) r_key_ok <= 1'b1;
                end
                S_INIT, S_ROUND: r_round <= r_round + 4'd1;
                S_OUTPUT: if (w_out_fire)
                    r_cnt <= (r_cnt == DB_LAST) ? 6'd0 : r_cnt + 6'd1;
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: if (w_in_fire) begin
                if (in_new_key) r_key <= {r_key[KEY_W_MAX-IO_W-1:0], in_data};
                else            r_data <= {r_data[127-IO_W:0], in_data};
            end
            S_LOAD_KEY: if (w_in_fire) r_key <= {r_key[KEY_W_MAX-IO_W-1:0], in_data};
            S_LOAD_DATA: if (w_in_fire) begin
                r_data <= {r_data[127-IO_W:0], in_data};
                // The loaded key occupies the low 32*Nk bits, word 0 highest
                if (r_cnt == DB_LAST && r_new_key)
                    for (int i = 0; i < KWORDS; i++)
                        if (i < int'(r_nk)) r_w[i] <= r_key[32*(int'(r_nk)-1-i) +: 32];
            end
            S_KEYEXP: r_w[r_cnt] <= w_new_word;
            S_INIT:   r_data <= r_data ^ w_rk;
            S_ROUND:  r_data <= aes_round(r_data, w_rk, r_round == w_nr);
            S_OUTPUT: if (w_out_fire) r_data <= {r_data[127-IO_W:0], {IO_W{1'b0}}};
            default: ;
        endcase
    end
endmodule

// File: tb/tb_aes_iter_core.sv
// tb_aes_iter_core: scoreboard bench for aes_iter_core.
// Drives an IO_W=8 instance and an IO_W=32 instance from one set of
// drivers (drv_sel picks the active one). Expected ciphertext is queued when a
// request is sent and popped when the block streams out.
module tb_aes_iter_core;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        drv_sel, drv_valid, drv_nk, drv_oready;
    logic [1:0]  drv_kl;
    logic [63:0] drv_data;

    logic       a_in_ready, a_out_valid, a_out_last, a_out_err, a_busy;
    logic [7:0] a_out_data;
    logic        b_in_ready, b_out_valid, b_out_last, b_out_err, b_busy;
    logic [31:0] b_out_data;

    aes_iter_core #(.IO_W(8), .KEY_W_MAX(256)) dut (
        .clk(clk), .rst(rst),
        .in_valid(drv_valid && !drv_sel), .in_ready(a_in_ready), .in_data(drv_data[63:56]),
        .in_new_key(drv_nk), .key_len(drv_kl),
        .out_valid(a_out_valid), .out_ready(drv_oready && !drv_sel), .out_data(a_out_data),
        .out_last(a_out_last), .out_err(a_out_err), .busy(a_busy)
    );

    aes_iter_core #(.IO_W(32), .KEY_W_MAX(256)) dut32 (
        .clk(clk), .rst(rst),
        .in_valid(drv_valid && drv_sel), .in_ready(b_in_ready), .in_data(drv_data[63:32]),
        .in_new_key(drv_nk), .key_len(drv_kl),
        .out_valid(b_out_valid), .out_ready(drv_oready && drv_sel), .out_data(b_out_data),
        .out_last(b_out_last), .out_err(b_out_err), .busy(b_busy)
    );

    logic        m_in_ready, m_out_valid, m_out_last, m_out_err, m_busy;
    logic [63:0] m_out_data;
    assign m_in_ready  = drv_sel ? b_in_ready  : a_in_ready;
    assign m_out_valid = drv_sel ? b_out_valid : a_out_valid;
    assign m_out_last  = drv_sel ? b_out_last  : a_out_last;
    assign m_out_err   = drv_sel ? b_out_err   : a_out_err;
    assign m_busy      = drv_sel ? b_busy      : a_busy;
    assign m_out_data  = drv_sel ? {b_out_data, 32'h0} : {a_out_data, 56'h0};

    int n_chk = 0;
    int n_err = 0;
    logic [128:0] sb_q [$];

    localparam logic [255:0] KEY128 = 256'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] KEY192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEYB   = 256'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PTB    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CTB    = 128'h3925841d02dc09fbdc118597196a0b32;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    task automatic put_beat(input logic [63:0] d, input bit gaps);
        int  t = 0;
        bit  rdy = 1'b0;
        if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        drv_valid = 1'b1;
        drv_data  = d;
        do begin
            @(negedge clk);
            rdy = m_in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!rdy && t < 200);
        if (!rdy) check("in_ready_timeout", 0, 1);
        drv_valid = 1'b0;
    endtask

    task automatic send_beats(input bit nk, input logic [1:0] kl, input int nkw,
                              input logic [255:0] key, input logic [127:0] pt, input bit gaps);
        int           w = drv_sel ? 32 : 8;
        logic [255:0] k;
        logic [127:0] p;
        drv_nk = nk;
        drv_kl = kl;
        k = key << (256 - 32 * nkw);
        p = pt;
        if (nk)
            for (int i = 0; i < 32 * nkw / w; i++) begin
                put_beat(k[255:192], gaps);
                k = k << w;
            end
        for (int i = 0; i < 128 / w; i++) begin
            put_beat(p[127:64], gaps);
            p = p << w;
        end
    endtask

    task automatic wait_lat(input int exp_lat);
        int lat = 0;
        while (!m_out_valid && lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
    endtask

    task automatic collect(input bit bp);
        int           w = drv_sel ? 32 : 8;
        int           nb = 128 / w;
        int           beat = 0;
        int           t = 0;
        bit           have = 1'b0;
        logic [128:0] e;
        logic [127:0] sh;
        logic [63:0]  mask, held;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        e    = sb_q.pop_front();
        sh   = e[127:0];
        mask = ~64'h0 << (64 - w);
        held = '0;
        while (beat < nb && t < 2000) begin
            drv_oready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (m_out_valid) begin
                if (have) check("hold_stable", m_out_data, held);
                held = m_out_data;
                have = 1'b1;
                check("in_ready_low_out", m_in_ready, 0);
                if (drv_oready) begin
                    check("out_data", m_out_data, e[128] ? 64'h0 : (sh[127:64] & mask));
                    check("out_last", m_out_last, beat == nb - 1);
                    check("out_err", m_out_err, e[128]);
                    sh   = sh << w;
                    beat++;
                    have = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            t++;
        end
        drv_oready = 1'b0;
        if (beat < nb) check("out_timeout", beat, nb);
        check("idle_ready", m_in_ready, 1);
    endtask

    task automatic run(input bit nk, input logic [1:0] kl, input int nkw, input logic [255:0] key,
                       input logic [127:0] pt, input logic [127:0] ct, input bit err,
                       input int exp_lat, input bit bp, input bit gaps);
        sb_q.push_back({err, ct});
        send_beats(nk, kl, nkw, key, pt, gaps);
        wait_lat(exp_lat);
        collect(bp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drv_sel = 1'b0; drv_valid = 1'b0; drv_nk = 1'b0; drv_oready = 1'b0;
        drv_kl = 2'b00; drv_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", a_in_ready, 0);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_busy", a_busy, 0);
        check("rst_out_data", a_out_data, 0);
        check("rst_out_last", a_out_last, 0);
        check("rst_out_err", a_out_err, 0);
        check("rst_in_ready32", b_in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", a_in_ready, 1);
        check("idle_busy", a_busy, 0);
        @(posedge clk);
        #1;

        run(1'b1, 2'b00, 4, KEY128, PT, CT128, 1'b0, 51, 1'b0, 1'b0);
        run(1'b1, 2'b01, 6, KEY192, PT, CT192, 1'b0, 59, 1'b0, 1'b1);
        run(1'b1, 2'b10, 8, KEY256, PT, CT256, 1'b0, 67, 1'b0, 1'b0);
        run(1'b1, 2'b00, 4, KEYB, PTB, CTB, 1'b0, 51, 1'b0, 1'b0);
        // key_len deliberately 10: a reuse must keep the stored AES-128 schedule
        run(1'b0, 2'b10, 4, '0, PTB, CTB, 1'b0, 11, 1'b1, 1'b0);

        send_beats(1'b1, 2'b00, 4, KEYB, PTB, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("busy_keyexp", a_busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", a_busy, 0);
        check("mid_rst_in_ready", a_in_ready, 0);
        check("mid_rst_out_valid", a_out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run(1'b0, 2'b00, 4, '0, PTB, '0, 1'b1, 1, 1'b0, 1'b0);
        run(1'b1, 2'b00, 4, KEY128, PT, CT128, 1'b0, 51, 1'b1, 1'b0);

        drv_sel = 1'b1;
        run(1'b1, 2'b10, 8, KEY256, PT, CT256, 1'b0, 67, 1'b1, 1'b0);
        run(1'b0, 2'b00, 8, '0, PT, CT256, 1'b0, 15, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/aes_iter_core.md
Name: aes_iter_core

Overview:
- Round-iterative AES encryption core supporting AES-128, AES-192 and AES-256. It is the parametrised successor to the unrolled byte-serial AES-128 top.
- Accepts key and plaintext as a word-serial stream of width IO_W and returns ciphertext the same way, using valid/ready handshakes on both sides.
- Expands the key once into an internal round-key store. Later blocks can reuse the stored key without reloading it.
- Reuses the existing subByte and MixColumns datapath blocks: 16 S-boxes for the state and 4 for key expansion.

Parameters:
- IO_W, 8, stream width in bits. Legal values are 8, 16, 32 and 64.
- KEY_W_MAX, 256, largest supported key size.
  - 256: all three key sizes supported.
  - 128: key_len is ignored and AES-128 is forced.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  core accepts an input beat
- in_data  in  IO_W  key or plaintext beat, MSB-first (FIPS-197 byte 0 first)
- in_new_key  in  1  sampled on the first beat of a request: 1 = key beats precede plaintext; 0 = reuse the stored key
- key_len  in  2  sampled with in_new_key=1: 00 = 128, 01 = 192, 10 = 256, 11 = treated as 128
- out_valid  out  1  ciphertext beat valid
- out_ready  in  1  sink accepts the beat
- out_data  out  IO_W  ciphertext beat, MSB-first
- out_last  out  1  marks the final beat of a block
- out_err  out  1  block was produced without a valid key; qualified by out_valid
- busy  out  1  high in any state other than IDLE

Behaviour:
- Derived values:
  - Nk = 4, 6 or 8; Nr = 10, 12 or 14.
  - Key beats KB = 32·Nk/IO_W. Data beats DB = 128/IO_W.
  - Expansion cycles E = 4(Nr+1) − Nk, i.e. 40, 46 or 52.
- A beat transfers on a clock edge where valid and ready are both high.
- States:
  - IDLE
  - LOAD_KEY: KB beats, shifted into the key register MSB-first.
  - LOAD_DATA: DB beats into the state register.
  - KEYEXP: one 32-bit word w[i] per cycle, i from Nk to 4Nr+3, written into a 60×32 word store. The first Nk words are copied from the key register on entry.
  - INIT: state ^= round key 0.
  - ROUND: one full round per cycle. Rounds 1..Nr−1 apply SubBytes, ShiftRows, MixColumns and AddRoundKey. Round Nr omits MixColumns.
  - OUTPUT: DB beats.
- Transitions:
  - IDLE, first beat accepted:
    - in_new_key=1: go to LOAD_KEY (that beat is key beat 0).
    - in_new_key=0: go to LOAD_DATA (that beat is data beat 0).
  - LOAD_KEY, after beat KB: go to LOAD_DATA.
  - LOAD_DATA, after beat DB: go to KEYEXP if a new key was loaded, otherwise INIT.
  - KEYEXP, after E cycles: set key_ok=1 and go to INIT.
  - INIT, after 1 cycle: go to ROUND.
  - ROUND, after Nr cycles: go to OUTPUT.
  - OUTPUT, after the last beat is accepted: go to IDLE.
- Latency from the edge accepting the last data beat to out_valid rising: (E if new key, else 0) + Nr + 1 edges. For AES-128 with a reused key this is 11 edges.
- in_ready:
  - High only in IDLE, LOAD_KEY and LOAD_DATA, and low while rst is high.
  - No overlap: the next request is not accepted until the final output beat is taken.
- out_valid:
  - High throughout OUTPUT.
  - out_data is held stable while out_ready=0.
  - out_last is high only on beat DB−1.
- Key store validity:
  - key_ok is cleared by reset, and also on entry to LOAD_KEY, so an interrupted load never leaves a stale key.
  - Request with in_new_key=0 and key_ok=0: the beats are consumed as plaintext, no rounds run (latency 1 edge). The block is returned with out_data = 0 and out_err = 1 on all beats.
- Reuse with in_new_key=0 uses the Nr of the stored key; key_len is ignored.
- Reset (any state, including mid-load or mid-KEYEXP):
  - Returns to IDLE.
  - Clears key_ok and the beat counters.
  - Output values: out_valid 0, out_data 0, out_last 0, out_err 0, busy 0, in_ready 0 during rst.
- in_valid low mid-load simply stalls the load; there is no timeout.

Test Plan:
- IO_W=8, new key, AES-128, key 000102…0f, pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a; 16+16 in beats; out_valid rises 51 edges after the last in beat; 16 out beats with out_last on the 16th.
- IO_W=8, key_len 01 with key 00…17, then key_len 10 with key 00…1f, same pt -> dda97ca4864cdfe06eaf70a0ec0d7191 (latency 59), then 8ea2b7ca516745bfeafc49904b496089 (latency 67).
- Key reuse: load key 2b7e151628aed2a6abf7158809cf4f3c with pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32. Repeat the pt with in_new_key=0 -> same ct after 16 in beats, latency 11.
- Backpressure: toggle out_ready pseudo-randomly during OUTPUT -> out_data stable while stalled, beat order unchanged, in_ready stays 0 until the last beat is accepted.
- Reset asserted mid-KEYEXP, then an in_new_key=0 request -> out_err=1, out_data=0. A following full new-key request gives the correct FIPS-197 ct.
- IO_W=32 build, AES-256 vector above -> 8 key beats + 4 data beats, 4 out beats of 8ea2b7ca, 516745bf, eafc4990, 4b496089.
